// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: FSM state encoding, SPI mode
// constants and synchronizer depth.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } spi_state_e;

  // Mode 0: sck idles low, data sampled on the leading (rising) edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  // Flops between the pin and the first usable synchronized copy.
  localparam int SYNC_STAGES = 2;

  // Bit counter width able to hold 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, plus single-cycle rise and
// fall pulses taken between the last sync stage and one extra history flop.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic d,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the pin through the synchronizer and keep one cycle of history.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old value.
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI target, mode 0, MSB first, fixed DATA_WIDTH-bit frames framed by cs_n.
// Receives a word into a valid/ready output and returns a word on miso.
// Optional feature macro: SPI_TARGET_OVERRUN_EN adds overrun_o / ovr_cnt_o.
module spi_target
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE_WORD = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  sck_i,
  input  logic                  cs_n_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  frame_err_o,
`ifdef SPI_TARGET_OVERRUN_EN
  output logic                  overrun_o,
  output logic [7:0]            ovr_cnt_o,
`endif
  output logic                  busy_o
);

  localparam int                CNT_W    = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  spi_state_e             state;
  logic [DATA_WIDTH-1:0]  tx_sh;
  logic [DATA_WIDTH-1:0]  rx_sh;
  logic [CNT_W-1:0]       bit_cnt;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_sync;
  logic                   sck_sync, sck_rise, sck_fall;
  logic                   cs_sync, cs_rise, cs_fall;
  logic                   sample_edge, shift_edge;
  logic [DATA_WIDTH-1:0]  tx_next;
  logic                   unused_sync;

  spi_sync_edge #(.RST_VAL(SPI_CPOL)) u_sck_sync (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .d      (sck_i),
    .sync_o (sck_sync),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  // cs_n resets to the deselected level so reset never fakes a falling edge.
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .d      (cs_n_i),
    .sync_o (cs_sync),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // Deselect is tracked as a level, so these two edge copies are not needed.
  assign unused_sync = sck_sync ^ cs_rise;

  // mosi only needs a synchronized level, aligned with the sck sync stages.
  always_ff @(posedge clk_i) begin
    if (!rst_n) mosi_q <= '0;
    else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
  end
  assign mosi_sync = mosi_q[SYNC_STAGES-1];

  assign sample_edge = SPI_CPHA ? sck_fall : sck_rise;
  assign shift_edge  = SPI_CPHA ? sck_rise : sck_fall;
  assign tx_next     = tx_valid_i ? tx_data_i : TX_IDLE_WORD;

  // The tx word is consumed exactly in the LOAD cycle, so ready is a state decode.
  assign tx_ready_o = (state == ST_LOAD) && tx_valid_i;
  assign busy_o     = (state != ST_IDLE);

  // Frame FSM: load tx word, shift both directions, deliver the rx word.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tx_sh       <= '0;
      rx_sh       <= '0;
      bit_cnt     <= '0;
      miso_o      <= 1'b0;
      miso_oe_o   <= 1'b0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef SPI_TARGET_OVERRUN_EN
      overrun_o   <= 1'b0;
      ovr_cnt_o   <= '0;
`endif
    end else begin
      frame_err_o <= 1'b0;
      miso_oe_o   <= ~cs_sync;

      if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
`ifdef SPI_TARGET_OVERRUN_EN
        overrun_o  <= 1'b0;
`endif
      end

      case (state)
        ST_IDLE: begin
          if (cs_fall) state <= ST_LOAD;
        end

        ST_LOAD: begin
          tx_sh   <= tx_next;
          miso_o  <= tx_next[DATA_WIDTH-1];
          bit_cnt <= '0;
          state   <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (sample_edge) begin
            // Completion wins over a cs_n release seen in the same cycle.
            rx_sh   <= {rx_sh[DATA_WIDTH-2:0], mosi_sync};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state <= ST_DONE;
          end else if (cs_sync) begin
            // A release with no bits is the tail of a completed frame (the
            // DONE->LOAD re-arm), not a truncated one.
            frame_err_o <= (bit_cnt != '0);
            state       <= ST_IDLE;
          end else if (shift_edge && (bit_cnt != '0)) begin
            // bit_cnt==0 here is the trailing edge of the previous frame.
            tx_sh  <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
            miso_o <= tx_sh[DATA_WIDTH-2];
          end
        end

        ST_DONE: begin
          if (!rx_valid_o || rx_ready_i) begin
            // NOTE: this later assignment overrides the handshake clear above.
            rx_data_o  <= rx_sh;
            rx_valid_o <= 1'b1;
          end else begin
`ifdef SPI_TARGET_OVERRUN_EN
            overrun_o <= 1'b1;
            if (ovr_cnt_o != 8'hFF) ovr_cnt_o <= ovr_cnt_o + 8'd1;
`endif
          end
          state <= cs_sync ? ST_IDLE : ST_LOAD;
        end

        default: state <= ST_IDLE;
      endcase

      if (cs_sync) miso_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Directed testbench for spi_target: sck = clk/8, hand-computed expected words.
// Build with +define+SPI_TARGET_OVERRUN_EN to also check the overrun outputs.
`timescale 1ns/1ps
module tb_spi_target;

  logic        clk_i      = 1'b0;
  logic        rst_n      = 1'b0;
  logic        sck_i      = 1'b0;
  logic        cs_n_i     = 1'b1;
  logic        mosi_i     = 1'b0;
  logic        miso_o;
  logic        miso_oe_o;
  logic [31:0] tx_data_i  = '0;
  logic        tx_valid_i = 1'b0;
  logic        tx_ready_o;
  logic [31:0] rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i = 1'b0;
  logic        frame_err_o;
  logic        busy_o;
`ifdef SPI_TARGET_OVERRUN_EN
  logic        overrun_o;
  logic [7:0]  ovr_cnt_o;
`endif

  int n_checks    = 0;
  int n_fail      = 0;
  int n_tx_ready  = 0;
  int n_frame_err = 0;
  int n_rx_valid  = 0;

  always #5 clk_i = ~clk_i;

  spi_target #(.DATA_WIDTH(32), .TX_IDLE_WORD(32'h0000_0000)) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .sck_i       (sck_i),
    .cs_n_i      (cs_n_i),
    .mosi_i      (mosi_i),
    .miso_o      (miso_o),
    .miso_oe_o   (miso_oe_o),
    .tx_data_i   (tx_data_i),
    .tx_valid_i  (tx_valid_i),
    .tx_ready_o  (tx_ready_o),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .frame_err_o (frame_err_o),
`ifdef SPI_TARGET_OVERRUN_EN
    .overrun_o   (overrun_o),
    .ovr_cnt_o   (ovr_cnt_o),
`endif
    .busy_o      (busy_o)
  );

  // Pulse / level counters sampled mid-cycle.
  always @(negedge clk_i) begin
    if (tx_ready_o)  n_tx_ready++;
    if (frame_err_o) n_frame_err++;
    if (rx_valid_o)  n_rx_valid++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic cs_start();
    cs_n_i = 1'b0;
    tick(8);
  endtask

  task automatic cs_end();
    tick(4);
    cs_n_i = 1'b1;
    tick(12);
  endtask

  // Mode 0 bits: mosi set while sck low, miso sampled just before the rise.
  task automatic shift_word(input logic [31:0] word, input int nbits,
                            output logic [31:0] miso_word);
    miso_word = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi_i = word[31-i];
      tick(4);
      miso_word[31-i] = miso_o;
      sck_i      = 1'b1;
      tx_valid_i = 1'b0;
      tick(4);
      sck_i = 1'b0;
    end
  endtask

  task automatic consume();
    rx_ready_i = 1'b1;
    tick(1);
    rx_ready_i = 1'b0;
    tick(1);
  endtask

  task automatic full_frame(input logic [31:0] word, output logic [31:0] miso_word);
    cs_start();
    shift_word(word, 32, miso_word);
    cs_end();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] miso_w;
    logic [31:0] dummy;
    int base_tx, base_fe, base_rx;

    // Reset state
    tick(5);
    check("rst_rx_valid", {31'd0, rx_valid_o}, 32'd0);
    check("rst_rx_data", rx_data_o, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_miso_oe", {31'd0, miso_oe_o}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // 1: full frame with a tx word offered
    base_tx = n_tx_ready; base_fe = n_frame_err;
    tx_data_i = 32'hDEAD_BEEF; tx_valid_i = 1'b1;
    cs_start();
    check("t1_busy", {31'd0, busy_o}, 32'd1);
    check("t1_miso_oe", {31'd0, miso_oe_o}, 32'd1);
    shift_word(32'hA5C3_0F01, 32, miso_w);
    cs_end();
    check("t1_rx_data", rx_data_o, 32'hA5C3_0F01);
    check("t1_rx_valid", {31'd0, rx_valid_o}, 32'd1);
    check("t1_miso", miso_w, 32'hDEAD_BEEF);
    check("t1_tx_ready", n_tx_ready - base_tx, 32'd1);
    check("t1_frame_err", n_frame_err - base_fe, 32'd0);
    check("t1_idle_miso_oe", {31'd0, miso_oe_o}, 32'd0);
    check("t1_idle_busy", {31'd0, busy_o}, 32'd0);
    consume();
    check("t1_rx_cleared", {31'd0, rx_valid_o}, 32'd0);

    // 2: no tx word -> idle word on miso
    base_tx = n_tx_ready;
    full_frame(32'h5A5A_1234, miso_w);
    check("t2_miso_idle", miso_w, 32'h0000_0000);
    check("t2_tx_ready", n_tx_ready - base_tx, 32'd0);
    check("t2_rx_data", rx_data_o, 32'h5A5A_1234);
    consume();

    // 3: truncated frame, then a clean one
    base_fe = n_frame_err; base_rx = n_rx_valid;
    cs_start();
    shift_word(32'hFFFF_FFFF, 12, dummy);
    cs_end();
    check("t3_frame_err", n_frame_err - base_fe, 32'd1);
    check("t3_no_rx_valid", n_rx_valid - base_rx, 32'd0);
    check("t3_busy", {31'd0, busy_o}, 32'd0);
    full_frame(32'h1234_5678, dummy);
    check("t3_rx_data", rx_data_o, 32'h1234_5678);
    check("t3_frame_err_after", n_frame_err - base_fe, 32'd1);
    consume();

    // 4: back-to-back frames, consumer stalled -> second word dropped
    cs_start();
    shift_word(32'h1111_1111, 32, dummy);
    shift_word(32'h2222_2222, 32, dummy);
    cs_end();
    check("t4_rx_data", rx_data_o, 32'h1111_1111);
    check("t4_rx_valid", {31'd0, rx_valid_o}, 32'd1);
`ifdef SPI_TARGET_OVERRUN_EN
    check("t4_overrun", {31'd0, overrun_o}, 32'd1);
    check("t4_ovr_cnt", {24'd0, ovr_cnt_o}, 32'd1);
`endif
    consume();
    check("t4_rx_cleared", {31'd0, rx_valid_o}, 32'd0);
`ifdef SPI_TARGET_OVERRUN_EN
    check("t4_overrun_clr", {31'd0, overrun_o}, 32'd0);
    check("t4_ovr_cnt_kept", {24'd0, ovr_cnt_o}, 32'd1);
`endif

    // 5: consumer always ready -> one single-cycle valid per frame
    rx_ready_i = 1'b1;
    base_rx = n_rx_valid;
    full_frame(32'h0F0F_0F0F, dummy);
    full_frame(32'h8000_0001, dummy);
    full_frame(32'hFFFF_FFFF, dummy);
    check("t5_valid_cycles", n_rx_valid - base_rx, 32'd3);
    check("t5_rx_data", rx_data_o, 32'hFFFF_FFFF);
    rx_ready_i = 1'b0;

    // 6: reset at bit 20 aborts the frame silently
    base_fe = n_frame_err;
    tx_data_i = 32'hFFFF_FFFF; tx_valid_i = 1'b1;
    cs_start();
    shift_word(32'hCAFE_F00D, 20, dummy);
    rst_n = 1'b0;
    tick(1);
    check("t6_busy", {31'd0, busy_o}, 32'd0);
    check("t6_miso", {31'd0, miso_o}, 32'd0);
    check("t6_miso_oe", {31'd0, miso_oe_o}, 32'd0);
    check("t6_rx_valid", {31'd0, rx_valid_o}, 32'd0);
    check("t6_rx_data", rx_data_o, 32'd0);
    check("t6_frame_err", {31'd0, frame_err_o}, 32'd0);
    check("t6_tx_ready", {31'd0, tx_ready_o}, 32'd0);
    cs_n_i = 1'b1; tx_valid_i = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(10);
    check("t6_no_err_pulse", n_frame_err - base_fe, 32'd0);
    full_frame(32'hCAFE_F00D, dummy);
    check("t6_rx_data_after", rx_data_o, 32'hCAFE_F00D);
    check("t6_rx_valid_after", {31'd0, rx_valid_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
